// File: rtl/ccd_window.sv
// Windowed correlation/phase detector: votes x1 against edges of a delayed x2,
// accumulates them in a saturating signed counter and dumps once per window.
module ccd_window #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16,
  parameter int DW    = 4,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x1_k,
  input  logic             x2_k,
  input  logic [DW-1:0]    delay_sel,
  input  logic [WIN_W-1:0] win_len,
  output logic [WIDTH-1:0] count_out,
  output logic             out,
  output logic             dump_valid,
  output logic             sat_out
);

  localparam logic signed [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW:0]             TAP_MAX = (DW+1)'(DEPTH-1);

  logic [DEPTH:0]           r_dl;
  logic signed [WIDTH-1:0]  r_acc;
  logic [WIN_W-1:0]         r_wcnt;
  logic                     r_satWin;
  logic [WIDTH-1:0]         r_countOut;
  logic                     r_satOut;
  logic                     r_dumpValid;

  logic [DW:0]              w_tap;
  logic                     w_x2d;
  logic                     w_x2dm1;
  logic                     w_up;
  logic                     w_down;
  logic signed [WIDTH-1:0]  w_accNext;
  logic                     w_satNow;
  logic                     w_freeRun;
  logic                     w_dump;

  // One extra index bit so the dm1 tap (sel+1) never wraps.
  always_comb begin
    w_tap = {1'b0, delay_sel};
    if ({1'b0, delay_sel} > TAP_MAX) begin
      w_tap = TAP_MAX;
    end
  end

  assign w_x2d   = r_dl[w_tap];
  assign w_x2dm1 = r_dl[w_tap + (DW+1)'(1)];
  assign w_up    = x1_k &  w_x2d & ~w_x2dm1;
  assign w_down  = x1_k & ~w_x2d &  w_x2dm1;

  always_comb begin
    w_accNext = r_acc;
    w_satNow  = 1'b0;
    if (w_up) begin
      if (r_acc == ACC_MAX) begin
        w_satNow = 1'b1;
      end else begin
        w_accNext = r_acc + WIDTH'(1);
      end
    end else if (w_down) begin
      if (r_acc == ACC_MIN) begin
        w_satNow = 1'b1;
      end else begin
        w_accNext = r_acc - WIDTH'(1);
      end
    end
  end

  // win_len is compared live, so shrinking it mid-window dumps on the next sample.
  assign w_freeRun = (win_len == '0);
  assign w_dump    = en && !w_freeRun && (r_wcnt >= (win_len - WIN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl <= '0;
    end else if (en) begin
      r_dl <= {r_dl[DEPTH-1:0], x2_k};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_wcnt   <= '0;
      r_satWin <= 1'b0;
    end else if (en) begin
      if (w_dump) begin
        r_acc    <= '0;
        r_wcnt   <= '0;
        r_satWin <= 1'b0;
      end else begin
        r_acc    <= w_accNext;
        r_satWin <= r_satWin | w_satNow;
        r_wcnt   <= w_freeRun ? '0 : r_wcnt + WIN_W'(1);
      end
    end
  end

  // Outputs hold between dumps; in free-run they shadow the accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_countOut  <= '0;
      r_satOut    <= 1'b0;
      r_dumpValid <= 1'b0;
    end else begin
      r_dumpValid <= w_dump;
      if (w_dump || (en && w_freeRun)) begin
        r_countOut <= w_accNext;
        r_satOut   <= r_satWin | w_satNow;
      end
    end
  end

  assign count_out  = r_countOut;
  assign out        = r_countOut[WIDTH-1];
  assign dump_valid = r_dumpValid;
  assign sat_out    = r_satOut;

endmodule
